// File: rtl/window_stream9x9_if.sv
// Pixel-stream in / parallel-window out bundle of the window generator.
// Producer side drives the raster stream; the window side is read by the inner-product unit.
interface window_stream9x9_if #(
  parameter int WIN   = 9,
  parameter int PIX_W = 7
);
  logic                     sof;
  logic                     pix_valid;
  logic [PIX_W-1:0]         pix_in;
  logic                     win_valid;
  logic [WIN*WIN*PIX_W-1:0] win_data;
  logic [7:0]               win_row;
  logic [7:0]               win_col;
  logic                     frame_done;

  modport master (
    output sof, pix_valid, pix_in,
    input  win_valid, win_data, win_row, win_col, frame_done
  );

  modport slave (
    input  sof, pix_valid, pix_in,
    output win_valid, win_data, win_row, win_col, frame_done
  );
endinterface

// File: rtl/window_stream9x9.sv
// Raster pixel stream -> WIN x WIN sliding window for the inner-product stage.
// Latency 1 cycle from accepting the bottom-right pixel; no backpressure, idle cycles freeze all state.
module window_stream9x9 #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int WIN   = 9,
  parameter int PIX_W = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  window_stream9x9_if.slave  bus
);
  localparam int         NB       = WIN - 1;
  localparam int         AW       = $clog2(IMG_W);
  localparam int         DW       = WIN * WIN * PIX_W;
  localparam logic [7:0] LAST_COL = 8'(IMG_W - 1);
  localparam logic [7:0] LAST_ROW = 8'(IMG_H - 1);
  localparam logic [7:0] EDGE     = 8'(WIN - 1);

  logic             accept;
  logic [7:0]       cur_col, cur_row;
  logic [AW-1:0]    addr;
  logic [7:0]       col_q, col_d, row_q, row_d;
  logic [7:0]       win_row_q, win_col_q;
  logic             win_valid_q, win_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [DW-1:0]    win_q, win_d;
  logic [PIX_W-1:0] lb_mem [NB][IMG_W];
  logic [PIX_W-1:0] slice  [WIN];

  // sof forces the accepted pixel to (0,0) without waiting for the counters.
  always_comb begin
    accept  = bus.pix_valid;
    cur_col = bus.sof ? '0 : col_q;
    cur_row = bus.sof ? '0 : row_q;
    addr    = cur_col[AW-1:0];
  end

  always_comb begin
    col_d = cur_col + 8'd1;
    row_d = cur_row;
    if (cur_col == LAST_COL) begin
      col_d = '0;
      row_d = (cur_row == LAST_ROW) ? '0 : cur_row + 8'd1;
    end
    win_valid_d  = accept && (cur_row >= EDGE) && (cur_col >= EDGE);
    frame_done_d = accept && (cur_col == LAST_COL) && (cur_row == LAST_ROW);
  end

  // Bottom row of the new slice is the live pixel; LB[i] supplies i+1 rows above.
  always_comb begin
    slice[WIN-1] = bus.pix_in;
    for (int i = 0; i < NB; i++) slice[WIN-2-i] = lb_mem[i][addr];
    win_d = win_q;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        if (c < WIN - 1) win_d[(r*WIN+c)*PIX_W +: PIX_W] = win_q[(r*WIN+c+1)*PIX_W +: PIX_W];
        else             win_d[(r*WIN+c)*PIX_W +: PIX_W] = slice[r];
      end
    end
  end

  // Cascaded line buffers addressed by column: each entry ages one row per write.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_mem[0][addr] <= bus.pix_in;
      for (int i = 1; i < NB; i++) lb_mem[i][addr] <= lb_mem[i-1][addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      if (accept) begin
        col_q     <= col_d;
        row_q     <= row_d;
        win_q     <= win_d;
        win_row_q <= cur_row;
        win_col_q <= cur_col;
      end
    end
  end

  assign bus.win_valid  = win_valid_q;
  assign bus.win_data   = win_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_window_stream9x9.sv
// Randomized bench for window_stream9x9 against an image-array reference model.
module tb_window_stream9x9;
  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int WIN   = 9;
  localparam int PIX_W = 7;
  localparam int DW    = WIN * WIN * PIX_W;
  typedef logic [DW-1:0] vec_t;

  logic clk;
  logic rst_n;

  window_stream9x9_if #(.WIN(WIN), .PIX_W(PIX_W)) bus ();

  window_stream9x9 #(.IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .PIX_W(PIX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int pulses;
  int img [IMG_H][IMG_W];
  int mrow;
  int mcol;

  task automatic chk(input string tag, input vec_t got, input vec_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, model the accept, sample at the next negedge.
  task automatic step(input bit v, input bit s, input logic [PIX_W-1:0] p);
    vec_t ed;
    bit   ev;
    bit   edn;
    int   er;
    int   ec;
    bus.pix_valid = v;
    bus.sof       = s;
    bus.pix_in    = p;
    ed = '0; ev = 1'b0; edn = 1'b0; er = 0; ec = 0;
    if (v) begin
      if (s) begin
        mrow = 0;
        mcol = 0;
      end
      img[mrow][mcol] = int'(p);
      ev  = (mrow >= WIN - 1) && (mcol >= WIN - 1);
      edn = (mrow == IMG_H - 1) && (mcol == IMG_W - 1);
      if (ev) begin
        for (int k = 0; k < WIN * WIN; k++)
          ed[k*PIX_W +: PIX_W] = PIX_W'(img[mrow-WIN+1+k/WIN][mcol-WIN+1+k%WIN]);
        er = mrow;
        ec = mcol;
      end
      mcol++;
      if (mcol == IMG_W) begin
        mcol = 0;
        mrow = (mrow == IMG_H - 1) ? 0 : mrow + 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("win_valid", vec_t'(bus.win_valid), vec_t'(ev));
    chk("frame_done", vec_t'(bus.frame_done), vec_t'(edn));
    if (bus.win_valid) pulses++;
    if (ev) begin
      chk("win_data", bus.win_data, ed);
      chk("win_row", vec_t'(bus.win_row), vec_t'(er));
      chk("win_col", vec_t'(bus.win_col), vec_t'(ec));
    end
  endtask

  // mode 0: ramp (row*28+col)%128, otherwise constant cval; gaps inserts random idle cycles.
  task automatic send_frame(input int mode, input int npix, input bit gaps, input int cval);
    logic [PIX_W-1:0] p;
    for (int i = 0; i < npix; i++) begin
      while (gaps && ($urandom_range(0, 1) == 0))
        step(1'b0, 1'($urandom_range(0, 1)), PIX_W'($urandom));
      p = (mode == 0) ? PIX_W'((i / IMG_W) * IMG_W + i % IMG_W) : PIX_W'(cval);
      step(1'b1, i == 0, p);
    end
  endtask

  initial begin
    total = 0; bad = 0; pulses = 0; mrow = 0; mcol = 0;
    bus.sof = 1'b0; bus.pix_valid = 1'b0; bus.pix_in = '0;
    rst_n = 1'b0;
    #2;
    chk("rst_win_valid", vec_t'(bus.win_valid), '0);
    chk("rst_frame_done", vec_t'(bus.frame_done), '0);
    chk("rst_win_data", bus.win_data, '0);
    chk("rst_win_row", vec_t'(bus.win_row), '0);
    chk("rst_win_col", vec_t'(bus.win_col), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Continuous ramp frame.
    pulses = 0;
    send_frame(0, IMG_W * IMG_H, 1'b0, 0);
    chk("ramp_pulses", vec_t'(pulses), vec_t'(400));

    // Same frame with random idle gaps.
    pulses = 0;
    send_frame(0, IMG_W * IMG_H, 1'b1, 0);
    chk("gap_pulses", vec_t'(pulses), vec_t'(400));

    // Abort at pixel 300 and restart with sof.
    send_frame(0, 300, 1'b0, 0);
    pulses = 0;
    send_frame(0, IMG_W * IMG_H, 1'b0, 0);
    chk("abort_pulses", vec_t'(pulses), vec_t'(400));

    // Asynchronous reset mid-frame, while a window is on the bus.
    send_frame(0, 300, 1'b0, 0);
    bus.pix_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_win_valid", vec_t'(bus.win_valid), '0);
    chk("arst_frame_done", vec_t'(bus.frame_done), '0);
    chk("arst_win_data", bus.win_data, '0);
    chk("arst_win_row", vec_t'(bus.win_row), '0);
    chk("arst_win_col", vec_t'(bus.win_col), '0);
    @(negedge clk);
    rst_n = 1'b1;
    mrow = 0;
    mcol = 0;
    pulses = 0;
    send_frame(0, IMG_W * IMG_H, 1'b0, 0);
    chk("post_rst_pulses", vec_t'(pulses), vec_t'(400));

    // Back-to-back constant frames.
    pulses = 0;
    send_frame(1, IMG_W * IMG_H, 1'b0, 5);
    send_frame(1, IMG_W * IMG_H, 1'b0, 100);
    chk("b2b_pulses", vec_t'(pulses), vec_t'(800));

    step(1'b0, 1'b0, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
